// File: rtl/softusb_dmemarb_pkg.sv
// Shared types for the softusb data-memory arbiter: byte lane and wait-counter widths.
package softusb_dmemarb_pkg;

   localparam int unsigned WAIT_W = 8;

   typedef logic [7:0]        byte_t;
   typedef logic [WAIT_W-1:0] wait_t;

endpackage

// File: rtl/softusb_dmemarb.sv
// Single-port data-memory arbiter between the softusb CPU and its DMA engine.
// The CPU wins by default; a DMA request refused max_wait times in a row is forced through.
module softusb_dmemarb
   import softusb_dmemarb_pkg::*;
#(
   parameter int unsigned dmem_width = 13,
   parameter int unsigned max_wait   = 15
) (
   input  logic                  usb_clk,
   input  logic                  usb_rst_n,

   input  logic                  cpu_en,
   input  logic                  cpu_we,
   input  logic [dmem_width-1:0] cpu_a,
   input  logic [7:0]            cpu_dw,
   output logic [7:0]            cpu_dr,
   output logic                  cpu_stall,

   input  logic                  dma_req,
   input  logic                  dma_we,
   input  logic [dmem_width-1:0] dma_a,
   input  logic [7:0]            dma_dw,
   output logic                  dma_ack,
   output logic [7:0]            dma_dr,
   output logic                  dma_rvalid,

   output logic                  mem_we,
   output logic [dmem_width-1:0] mem_a,
   output logic [7:0]            mem_dw,
   input  logic [7:0]            mem_dr
);

   wait_t wait_cnt_d, wait_cnt_q;
   logic  rd_dma_d, rd_dma_q;
   logic  force_dma;
   logic  dma_gnt;
   logic  cpu_gnt;

   assign force_dma = (wait_cnt_q == wait_t'(max_wait));

   // Grants are qualified by usb_rst_n so every control output is quiet while reset is held.
   assign dma_gnt = usb_rst_n & dma_req & (~cpu_en | force_dma);
   assign cpu_gnt = usb_rst_n & cpu_en & ~dma_gnt;

   always_comb begin
      // NOTE: the hold value is assigned first so every path drives wait_cnt_d and no latch is inferred.
      wait_cnt_d = wait_cnt_q;
      if (!dma_req || dma_gnt) begin
         wait_cnt_d = '0;
      end else if (!force_dma) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   assign rd_dma_d = dma_gnt & ~dma_we;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge usb_clk or negedge usb_rst_n) begin
      if (!usb_rst_n) begin
         wait_cnt_q <= '0;
         rd_dma_q   <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         rd_dma_q   <= rd_dma_d;
      end
   end

   assign mem_we = dma_gnt ? dma_we : (cpu_gnt & cpu_we);
   assign mem_a  = dma_gnt ? dma_a  : cpu_a;
   assign mem_dw = dma_gnt ? dma_dw : cpu_dw;

   assign cpu_stall  = cpu_en & dma_gnt;
   assign dma_ack    = dma_gnt;
   assign dma_rvalid = rd_dma_q;

   // Both requesters see the RAM output directly; the valid flag tells DMA which cycle is its own.
   assign dma_dr = mem_dr;
   assign cpu_dr = mem_dr;

endmodule
